ux607_pwm_ncore: RTL and testbench
==================================

// Module: ux607_pwm_ncore
// PURPOSE
//  Native-ICB, parametrised PWM peripheral. Successor to the fixed 4-channel, TileLink-bridged PWM.
//  Has one prescaled counter and NCH compare channels.
//  New over the fixed version: per-channel output polarity, shadowed (period-synchronous) compare
//  update, W1C interrupt pending. Sits on the peripheral ICB bus; irq[] goes to PLIC, pwm_o[] to GPIO IOF.
// PARAMETERS
//  NCH     4   number of compare channels / outputs (1..8)
//  CW      16  compare/counter width in bits (8..16)
//  AW      32  ICB address width; only addr[7:2] decoded
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    async active-low reset
//  i_icb_cmd_valid  in   1    command valid
//  i_icb_cmd_ready  out  1    command ready
//  i_icb_cmd_addr   in   AW   byte address (word aligned)
//  i_icb_cmd_read   in   1    1=read, 0=write
//  i_icb_cmd_wdata  in   32   write data (full-word writes only)
//  i_icb_rsp_valid  out  1    response valid
//  i_icb_rsp_ready  in   1    response ready
//  i_icb_rsp_rdata  out  32   read data (0 for writes)
//  i_icb_rsp_err    out  1    unmapped-address error
//  irq              out  NCH  ip[i] & ie[i]
//  pwm_o            out  NCH  ip[i] ^ inv[i]
// BEHAVIOUR
//  Reset: every register is 0. cmd_ready=1, rsp_valid=0, rsp_err=0, irq=0, pwm_o=0.
//  ICB: one outstanding transaction. cmd_ready = ~rsp_valid | rsp_ready.
//   Accept = valid & ready. rsp_valid/rdata/err are registered and appear 1 cycle after accept.
//   rsp is held stable while rsp_ready=0. Write side effects take effect at the accept edge.
//  Register map (addr[7:0]):
//   00 CFG: [3:0] scale, [8] sticky, [9] zerocmp, [12] enalways, [13] enoneshot, [14] shadow_en
//   04 IP: [NCH-1:0]. Read = pending; write 1 = clear.
//   08 IE. 0C INV. 10 COUNT (s, zero-extended; write loads s and clears pre).
//   20+4*i CMPi [CW-1:0]. Read returns the last written (shadow) value.
//   Other offsets: read rdata=0, err=1; writes ignored, err=1.
//  Counter: en = enalways | enoneshot.
//   While en, the 15-bit pre counts every cycle. tick = (pre == 2^scale-1); on tick, pre <= 0.
//   On tick: if zerocmp & (s >= cmp_act[0]) or s == all-ones, then s <= 0 ("wrap"); else s <= s+1.
//   On wrap: enoneshot <= 0 (oneshot stops at s=0); cmp_act[*] <= cmp_sh[*] when shadow_en.
//   en=0: pre and s hold.
//  Compare: while en, ip[i] is set on the cycle after (s >= cmp_act[i]), i.e. 1-cycle lag.
//   sticky=0: ip[i] also clears on the cycle after (s < cmp_act[i]).
//   sticky=1: ip[i] holds until W1C. en=0: ip holds.
//  Shadow: shadow_en=0 -> CMP write updates cmp_sh and cmp_act together.
//   shadow_en=1 -> CMP write updates cmp_sh only.
//  Simultaneous events:
//   COUNT write vs tick: write wins.
//   W1C vs hardware set in the same cycle: set wins.
//   CMP write on the wrap cycle: wrap copies the pre-edge shadow; the new value applies at the next wrap.
//   CFG write vs oneshot clear: the written enoneshot value wins.
//  Reset mid-operation: all state returns to reset values asynchronously. An in-flight rsp is dropped.
// TESTING
//  1 Reset -> cmd_ready=1, irq=0, pwm_o=0. Reads of 00..10 and 20..(20+4*(NCH-1)) return 0, err=0.
//  2 scale=0, zerocmp, enalways, CMP0=3, CMP1=2 -> s cycles 0,1,2,3.
//    pwm_o[1] high 2 of every 4 clk, lagging s by 1 cycle. INV=2 -> pwm_o[1] inverted.
//  3 scale=2, enalways, no zerocmp -> COUNT read 40 cycles after enable returns 10.
//    COUNT=0xFFFF wraps to 0 after 4 cycles.
//  4 enoneshot, zerocmp, CMP0=5, scale=0 -> after 6 ticks s=0 stays. CFG[13] reads 0.
//  5 sticky, IE=4, CMP2=3 -> irq[2]=1 from s=3 and stays across wrap.
//    Write IP=4 -> irq[2]=0 next cycle (re-sets if s>=3 still true).
//  6 shadow_en, CMP1 2->1 written mid-period -> duty unchanged until the next wrap.
//    Read 0x40 -> rdata=0, err=1. rsp_ready=0 for 3 cycles -> rsp held, cmd_ready=0.

Source files
------------

// File: rtl/ux607_pwm_ncore_if.sv
// ICB slave-port bundle for the PWM peripheral.
//   cmd_valid/cmd_ready  command handshake
//   cmd_addr             byte address (word aligned)
//   cmd_read             1 = read, 0 = write
//   cmd_wdata            write data (full-word writes only)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes)
//   rsp_err              unmapped-address error
// master: the bus side issuing commands; slave: the peripheral.
interface ux607_pwm_ncore_if #(
  parameter int unsigned AW = 32
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_read;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ux607_pwm_ncore.sv
// Parametrised PWM peripheral on a native ICB slave port.
// One prescaled counter s, NCH compare channels with shadowed compare values,
// per-channel output polarity and W1C interrupt pending bits.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_icb       ICB slave port (one outstanding transaction, registered response)
//   irq[NCH]    ip & ie, to the interrupt controller
//   pwm_o[NCH]  ip ^ inv, to the GPIO IOF mux
// Register map (addr[7:2] decoded): 00 CFG, 04 IP, 08 IE, 0C INV, 10 COUNT, 20+4*i CMPi.
module ux607_pwm_ncore #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16,
  parameter int unsigned AW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ux607_pwm_ncore_if.slave i_icb,
  output logic [NCH-1:0]   irq,
  output logic [NCH-1:0]   pwm_o
);
  localparam int unsigned PW = 15;

  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [5:0]    word;
  logic          unused_bits;

  assign addr        = i_icb.cmd_addr;
  assign wdata       = i_icb.cmd_wdata;
  assign word        = addr[7:2];
  assign unused_bits = ^{addr, wdata};

  // Configuration
  logic [3:0] scale_q, scale_d;
  logic       sticky_q, sticky_d;
  logic       zerocmp_q, zerocmp_d;
  logic       enalways_q, enalways_d;
  logic       enoneshot_q, enoneshot_d;
  logic       shadow_en_q, shadow_en_d;

  logic [NCH-1:0] ip_q, ip_d;
  logic [NCH-1:0] ie_q, ie_d;
  logic [NCH-1:0] inv_q, inv_d;

  logic [CW-1:0] s_q, s_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cmp_sh_q  [NCH];
  logic [CW-1:0] cmp_sh_d  [NCH];
  logic [CW-1:0] cmp_act_q [NCH];
  logic [CW-1:0] cmp_act_d [NCH];

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // Bus handshake
  logic cmd_ready, accept, wr;

  assign cmd_ready = ~rsp_valid_q | i_icb.rsp_ready;
  assign accept    = i_icb.cmd_valid & cmd_ready;
  assign wr        = accept & ~i_icb.cmd_read;

  assign i_icb.cmd_ready = cmd_ready;
  assign i_icb.rsp_valid = rsp_valid_q;
  assign i_icb.rsp_rdata = rsp_rdata_q;
  assign i_icb.rsp_err   = rsp_err_q;

  // Address decode
  logic           sel_cfg, sel_ip, sel_ie, sel_inv, sel_cnt, mapped;
  logic [NCH-1:0] sel_cmp;

  assign sel_cfg = (word == 6'd0);
  assign sel_ip  = (word == 6'd1);
  assign sel_ie  = (word == 6'd2);
  assign sel_inv = (word == 6'd3);
  assign sel_cnt = (word == 6'd4);

  always_comb begin
    sel_cmp = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sel_cmp[i] = (word == 6'(8 + i));
    end
  end

  assign mapped = sel_cfg | sel_ip | sel_ie | sel_inv | sel_cnt | (|sel_cmp);

  // Read mux; CMP reads return the shadow (last written) value
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (sel_cfg) begin
      rd_data[3:0] = scale_q;
      rd_data[8]   = sticky_q;
      rd_data[9]   = zerocmp_q;
      rd_data[12]  = enalways_q;
      rd_data[13]  = enoneshot_q;
      rd_data[14]  = shadow_en_q;
    end
    if (sel_ip)  rd_data[NCH-1:0] = ip_q;
    if (sel_ie)  rd_data[NCH-1:0] = ie_q;
    if (sel_inv) rd_data[NCH-1:0] = inv_q;
    if (sel_cnt) rd_data[CW-1:0]  = s_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_cmp[i]) rd_data[CW-1:0] = cmp_sh_q[i];
    end
  end

  // Counter control
  logic          en, tick, wrap;
  logic [PW:0]   pre_mask;

  assign en       = enalways_q | enoneshot_q;
  assign pre_mask = (16'd1 << scale_q) - 16'd1;
  assign tick     = en & ({1'b0, pre_q} == pre_mask);
  assign wrap     = tick & ((zerocmp_q & (s_q >= cmp_act_q[0])) | (&s_q));

  always_comb begin
    scale_d     = scale_q;
    sticky_d    = sticky_q;
    zerocmp_d   = zerocmp_q;
    enalways_d  = enalways_q;
    enoneshot_d = enoneshot_q;
    shadow_en_d = shadow_en_q;
    ip_d        = ip_q;
    ie_d        = ie_q;
    inv_d       = inv_q;
    s_d         = s_q;
    pre_d       = pre_q;
    cmp_sh_d    = cmp_sh_q;
    cmp_act_d   = cmp_act_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    // Response: captured at accept, held until rsp_ready
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = i_icb.cmd_read ? rd_data : 32'h0;
      rsp_err_d   = ~mapped;
    end else if (i_icb.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) s_d = wrap ? '0 : s_q + CW'(1);
    end

    if (wrap) begin
      enoneshot_d = 1'b0;
      // Uses the pre-edge shadow, so a CMP write on the wrap cycle waits a period
      if (shadow_en_q) cmp_act_d = cmp_sh_q;
    end

    // W1C first, then the hardware set so a same-cycle set wins
    if (wr && sel_ip) ip_d = ip_q & ~wdata[NCH-1:0];
    if (en) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (s_q >= cmp_act_q[i]) begin
          ip_d[i] = 1'b1;
        end else if (!sticky_q) begin
          ip_d[i] = 1'b0;
        end
      end
    end

    // Register writes override the counter's own updates
    if (wr) begin
      if (sel_cfg) begin
        scale_d     = wdata[3:0];
        sticky_d    = wdata[8];
        zerocmp_d   = wdata[9];
        enalways_d  = wdata[12];
        enoneshot_d = wdata[13];
        shadow_en_d = wdata[14];
      end
      if (sel_ie)  ie_d  = wdata[NCH-1:0];
      if (sel_inv) inv_d = wdata[NCH-1:0];
      if (sel_cnt) begin
        s_d   = wdata[CW-1:0];
        pre_d = '0;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (sel_cmp[i]) begin
          cmp_sh_d[i] = wdata[CW-1:0];
          if (!shadow_en_q) cmp_act_d[i] = wdata[CW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q     <= '0;
      sticky_q    <= 1'b0;
      zerocmp_q   <= 1'b0;
      enalways_q  <= 1'b0;
      enoneshot_q <= 1'b0;
      shadow_en_q <= 1'b0;
      ip_q        <= '0;
      ie_q        <= '0;
      inv_q       <= '0;
      s_q         <= '0;
      pre_q       <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cmp_sh_q[i]  <= '0;
        cmp_act_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      scale_q     <= scale_d;
      sticky_q    <= sticky_d;
      zerocmp_q   <= zerocmp_d;
      enalways_q  <= enalways_d;
      enoneshot_q <= enoneshot_d;
      shadow_en_q <= shadow_en_d;
      ip_q        <= ip_d;
      ie_q        <= ie_d;
      inv_q       <= inv_d;
      s_q         <= s_d;
      pre_q       <= pre_d;
      cmp_sh_q    <= cmp_sh_d;
      cmp_act_q   <= cmp_act_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign irq   = ip_q & ie_q;
  assign pwm_o = ip_q ^ inv_q;

endmodule

// File: tb/tb_ux607_pwm_ncore.sv
// Bench for ux607_pwm_ncore: directed scenarios plus random register traffic,
// checked against a cycle-level behavioural model. Expected responses are queued
// at accept time and popped by an independent response monitor.
module tb_ux607_pwm_ncore;
  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int AW   = 32;
  localparam int SMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ux607_pwm_ncore_if #(.AW(AW)) bus ();
  logic [NCH-1:0] irq;
  logic [NCH-1:0] pwm_o;

  ux607_pwm_ncore #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_icb (bus),
    .irq   (irq),
    .pwm_o (pwm_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  int m_scale, m_ip, m_ie, m_inv, m_s, m_pre;
  bit m_sticky, m_zc, m_ea, m_eo, m_sh_en, m_pend;
  int m_sh[NCH];
  int m_act[NCH];

  function automatic void m_reset();
    m_scale = 0; m_ip = 0; m_ie = 0; m_inv = 0; m_s = 0; m_pre = 0;
    m_sticky = 0; m_zc = 0; m_ea = 0; m_eo = 0; m_sh_en = 0; m_pend = 0;
    for (int c = 0; c < NCH; c++) begin
      m_sh[c] = 0;
      m_act[c] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic bit m_mapped(input int off);
    return (off <= 16) || (off >= 32 && off < 32 + 4 * NCH);
  endfunction

  function automatic logic [31:0] m_regval(input int off);
    case (off)
      0:  return 32'(m_scale) | (32'(m_sticky) << 8) | (32'(m_zc) << 9) |
                 (32'(m_ea) << 12) | (32'(m_eo) << 13) | (32'(m_sh_en) << 14);
      4:  return 32'(m_ip);
      8:  return 32'(m_ie);
      12: return 32'(m_inv);
      16: return 32'(m_s);
      default: begin
        if (off >= 32 && off < 32 + 4 * NCH) return 32'(m_sh[(off - 32) / 4]);
        return 32'h0;
      end
    endcase
  endfunction

  // Advance the model across one rising edge, given the inputs presented to it.
  function automatic void m_step();
    bit          rd, acc, wr, en, sh_en0, tick, wrap;
    int          off, nip, c;
    logic [31:0] w;
    rsp_t        r;
    rd     = bus.cmd_read;
    acc    = bus.cmd_valid && (!m_pend || bus.rsp_ready);
    wr     = acc && !rd;
    off    = 4 * int'(bus.cmd_addr[7:2]);
    w      = bus.cmd_wdata;
    en     = m_ea || m_eo;
    sh_en0 = m_sh_en;
    tick   = en && (m_pre == (1 << m_scale) - 1);
    wrap   = tick && ((m_zc && m_s >= m_act[0]) || m_s == SMAX);

    if (acc) begin
      r.rdata = rd ? m_regval(off) : 32'h0;
      r.err   = !m_mapped(off);
      exp_q.push_back(r);
      m_pend = 1;
    end else if (bus.rsp_ready) begin
      m_pend = 0;
    end

    nip = m_ip;
    if (wr && off == 4) nip = nip & ~int'(w[NCH-1:0]);
    if (en) begin
      for (int k = 0; k < NCH; k++) begin
        if (m_s >= m_act[k]) nip = nip | (1 << k);
        else if (!m_sticky)  nip = nip & ~(1 << k);
      end
    end
    m_ip = nip;

    if (en) begin
      m_pre = tick ? 0 : (m_pre + 1) % 32768;
      if (tick) m_s = wrap ? 0 : m_s + 1;
    end
    if (wrap) begin
      m_eo = 0;
      if (sh_en0) for (int k = 0; k < NCH; k++) m_act[k] = m_sh[k];
    end

    if (wr) begin
      case (off)
        0: begin
          m_scale = int'(w[3:0]); m_sticky = w[8]; m_zc = w[9];
          m_ea = w[12]; m_eo = w[13]; m_sh_en = w[14];
        end
        8:  m_ie  = int'(w[NCH-1:0]);
        12: m_inv = int'(w[NCH-1:0]);
        16: begin m_s = int'(w) & SMAX; m_pre = 0; end
        default: begin
          if (off >= 32 && off < 32 + 4 * NCH) begin
            c = (off - 32) / 4;
            m_sh[c] = int'(w) & SMAX;
            if (!sh_en0) m_act[c] = m_sh[c];
          end
        end
      endcase
    end
  endfunction

  // Model/output checker: runs between edges, once per cycle
  always begin
    @(negedge clk); #2;
    if (!rst_n) begin
      m_reset();
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_pwm", 32'(pwm_o), 32'h0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    end else begin
      check("irq", 32'(irq), 32'(m_ip & m_ie));
      check("pwm_o", 32'(pwm_o), 32'((m_ip ^ m_inv) & ((1 << NCH) - 1)));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_pend || bus.rsp_ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_pend));
      m_step();
    end
  end

  // Response monitor: compares every cycle a response is presented, pops on handshake
  always begin
    @(negedge clk); #2;
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected at %0t: got rdata %0h, expected no response",
                 $time, bus.rsp_rdata);
      end else begin
        check("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // rsp_ready driver: 0 random, 1 always high, 2 always low
  int rdy_mode = 1;
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.rsp_ready = 1'b1;
        2:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic icb(input logic [7:0] off, input bit rd, input logic [31:0] wd);
    int          guard;
    logic [31:0] r;
    guard = 0;
    r = $urandom;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = {r[31:8], off};
    bus.cmd_read  = rd;
    bus.cmd_wdata = wd;
    #1;
    while (!bus.cmd_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL icb_accept_timeout at %0t: got cmd_ready 0, expected 1", $time);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wr32(input logic [7:0] off, input logic [31:0] wd);
    icb(off, 1'b0, wd);
  endtask

  task automatic rd32(input logic [7:0] off);
    icb(off, 1'b1, $urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [31:0] STICKY = 32'h100, ZC = 32'h200, EA = 32'h1000, EO = 32'h2000,
                          SHEN = 32'h4000;

  initial begin
    logic [7:0]  off;
    logic [31:0] wd;
    bit          rd;
    int          pick;

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_read  = 1'b0;
    bus.cmd_wdata = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset readback of every mapped register
    for (int a = 0; a <= 16; a += 4) rd32(8'(a));
    for (int c = 0; c < NCH; c++) rd32(8'(32 + 4 * c));

    // Free-running 0..3 with two compare channels, then inverted polarity
    wr32(8'h20, 3);
    wr32(8'h24, 2);
    wr32(8'h00, ZC | EA);
    idle(20);
    wr32(8'h0C, 2);
    idle(12);
    wr32(8'h0C, 0);

    // Prescaler 4, no compare wrap; then wrap through all-ones
    wr32(8'h00, 0);
    wr32(8'h10, 0);
    wr32(8'h00, EA | 2);
    idle(38);
    rd32(8'h10);
    wr32(8'h10, SMAX);
    idle(6);
    rd32(8'h10);

    // Oneshot stops at zero
    wr32(8'h00, 0);
    wr32(8'h10, 0);
    wr32(8'h20, 5);
    wr32(8'h00, EO | ZC);
    idle(12);
    rd32(8'h00);
    rd32(8'h10);

    // Sticky interrupt and W1C
    wr32(8'h00, 0);
    wr32(8'h10, 0);
    wr32(8'h08, 4);
    wr32(8'h28, 3);
    wr32(8'h00, STICKY | ZC | EA);
    idle(20);
    wr32(8'h04, 4);
    idle(3);
    rd32(8'h04);
    wr32(8'h00, ZC | EA);
    idle(4);
    wr32(8'h04, 4);
    idle(3);

    // Shadowed compare update mid-period
    wr32(8'h20, 7);
    wr32(8'h24, 2);
    wr32(8'h00, SHEN | ZC | EA);
    idle(11);
    wr32(8'h24, 1);
    rd32(8'h24);
    idle(20);

    // Unmapped read with a stalled response
    rdy_mode = 1;
    idle(2);
    rdy_mode = 2;
    idle(2);
    rd32(8'h40);
    idle(3);
    check("stall_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    rdy_mode = 1;
    idle(2);
    wr32(8'h40, 32'h5);

    // Reset with a response in flight
    rdy_mode = 2;
    idle(2);
    rd32(8'h00);
    rst_n = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    rdy_mode = 1;
    rd32(8'h00);
    rd32(8'h10);

    // Random traffic
    rdy_mode = 0;
    for (int k = 0; k < 300; k++) begin
      pick = $urandom_range(0, 11);
      wd   = $urandom;
      rd   = ($urandom_range(0, 9) < 4);
      case (pick)
        0: begin off = 8'h00; wd = (wd & 32'h7300) | 32'($urandom_range(0, 2)); end
        1: off = 8'h04;
        2: off = 8'h08;
        3: off = 8'h0C;
        4: begin
          off = 8'h10;
          wd = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 8))
                                           : 32'(SMAX - $urandom_range(0, 3));
        end
        5, 6, 7, 8: begin off = 8'(32 + 4 * (pick - 5)); wd = 32'($urandom_range(0, 12)); end
        9:  off = 8'h14;
        10: off = 8'h40;
        default: off = 8'hFC;
      endcase
      icb(off, rd, wd);
      idle($urandom_range(0, 3));
    end

    rdy_mode = 1;
    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: got no end of test, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
